// File: rtl/spi_pkg.sv
// spi_pkg: shared byte type and burst sequencer state encoding
package spi_pkg;
   typedef logic [7:0] byte_t;
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_START, S_WAIT, S_STORE, S_GAP, S_FIN
   } burst_state_e;
endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous byte FIFO with async active-high reset
// Ports: clk_i/rst_i clock and reset; wr_i/wdata_i push side; rd_i/rdata_o pop side;
// full_o/empty_o status. rdata_o reads 0 while empty.
module spi_byte_fifo import spi_pkg::*; #(
   parameter int DEPTH = 8
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  wr_i,
   input  byte_t wdata_i,
   input  logic  rd_i,
   output byte_t rdata_o,
   output logic  full_o,
   output logic  empty_o
);
   localparam int AW = $clog2(DEPTH);
   byte_t        mem_q [DEPTH];
   logic [AW:0]  wp_q, rp_q;
   logic         do_push, do_pop;
   // extra pointer bit separates full from empty when the index bits match
   assign empty_o = wp_q == rp_q;
   assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign do_pop  = rd_i && !empty_o;
   assign do_push = wr_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop) rp_q <= rp_q + 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: multi-byte burst sequencer driving a byte-level SPI master
// Ports: clk/rst; cmd_valid/cmd_ready/cmd_len/cmd_cpol/cmd_cpha command channel;
// tx_data/tx_valid/tx_ready TX byte stream; rx_data/rx_valid/rx_ready RX byte stream;
// busy/xfer_done status; spi_start/spi_data_in/spi_cpol/spi_cpha/spi_done/spi_data_out master link.
module spi_burst_ctrl import spi_pkg::*; #(
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_cpol,
   input  logic             cmd_cpha,
   input  byte_t            tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output byte_t            rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             busy,
   output logic             xfer_done,
   output logic             spi_start,
   output byte_t            spi_data_in,
   output logic             spi_cpol,
   output logic             spi_cpha,
   input  logic             spi_done,
   input  byte_t            spi_data_out
);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   burst_state_e     state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [GW-1:0]    gap_q, gap_d;
   byte_t            data_q, data_d, rxb_q, rxb_d;
   logic             cpol_q, cpol_d, cpha_q, cpha_d;
   logic             done_q, rdy_q, xfer_q;
   logic             tx_pop, tx_empty, tx_full, rx_push, rx_full, rx_empty;
   byte_t            tx_head;
   spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
      .clk_i(clk), .rst_i(rst), .wr_i(tx_valid && tx_ready), .wdata_i(tx_data),
      .rd_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
   );
   spi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
      .clk_i(clk), .rst_i(rst), .wr_i(rx_push), .wdata_i(rxb_q),
      .rd_i(rx_ready), .rdata_o(rx_data), .full_o(rx_full), .empty_o(rx_empty)
   );
   assign tx_ready    = !tx_full;
   assign rx_valid    = !rx_empty;
   // rdy_q keeps cmd_ready low while reset is held and for the release cycle's edge
   assign cmd_ready   = rdy_q && state_q == S_IDLE;
   assign busy        = state_q != S_IDLE;
   assign spi_start   = state_q == S_START;
   assign xfer_done   = xfer_q;
   assign spi_data_in = data_q;
   assign spi_cpol    = cpol_q;
   assign spi_cpha    = cpha_q;
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      data_d  = data_q;
      rxb_d   = rxb_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      tx_pop  = 1'b0;
      rx_push = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_valid && cmd_ready) begin
            rem_d   = cmd_len;
            cpol_d  = cmd_cpol;
            cpha_d  = cmd_cpha;
            state_d = cmd_len == '0 ? S_FIN : S_FETCH;
         end
         S_FETCH: if (!tx_empty) begin
            tx_pop  = 1'b1;
            data_d  = tx_head;
            state_d = S_START;
         end
         S_START: state_d = S_WAIT;
         // only a fresh rising edge counts; a level left over from the last byte is ignored
         S_WAIT: if (spi_done && !done_q) begin
            rxb_d   = spi_data_out;
            state_d = S_STORE;
         end
         S_STORE: if (!rx_full) begin
            rx_push = 1'b1;
            rem_d   = rem_q - LEN_W'(1);
            state_d = rem_q == LEN_W'(1) ? S_FIN : S_GAP;
         end
         S_GAP: begin
            gap_d   = gap_q == GW'(GAP_CYCLES - 1) ? '0 : gap_q + GW'(1);
            state_d = gap_q == GW'(GAP_CYCLES - 1) ? S_FETCH : S_GAP;
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         gap_q   <= '0;
         data_q  <= '0;
         rxb_q   <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
         xfer_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         data_q  <= data_d;
         rxb_q   <= rxb_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         done_q  <= spi_done;
         rdy_q   <= 1'b1;
         xfer_q  <= state_q == S_FIN;
      end
   end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// tb_spi_burst_ctrl: randomized self-checking bench with loopback master and queue reference model
module tb_spi_burst_ctrl;
   import spi_pkg::*;
   localparam int GAP = 2;
   logic       clk = 1'b0, rst = 1'b1;
   logic       cmd_valid = 1'b0, cmd_cpol = 1'b0, cmd_cpha = 1'b0, cmd_ready;
   logic [7:0] cmd_len = '0;
   byte_t      tx_data = '0, rx_data, spi_data_in;
   byte_t      spi_data_out = '0;
   logic       tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b1;
   logic       busy, xfer_done, spi_start, spi_cpol, spi_cpha;
   logic       spi_done = 1'b1;
   int         errs = 0, checks = 0, cyc = 0;
   int         sn = 0, dn = 0, dcyc = 0, rx_n = 0, ml = 0, mt = 0;
   int         st_cyc [256], st_lat [256];
   logic [1:0] st_pol [256];
   byte_t      got_rx [512];
   byte_t      tx_model[$], exp_rx[$];
   int         need = 0, rx_seen = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_burst_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .xfer_done(xfer_done), .spi_start(spi_start), .spi_data_in(spi_data_in),
      .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_done(spi_done), .spi_data_out(spi_data_out)
   );

   // Loopback master plus observers. Done drops two cycles after start so a level
   // check would see a stale high; done rises ml cycles after start with miso=mosi.
   always @(negedge clk) begin
      if (rst) begin
         ml = 0;
         mt = 0;
      end else begin
         if (spi_start) begin
            ml = $urandom_range(3, 6);
            mt = 0;
            if (sn < 256) begin
               st_cyc[sn] = cyc;
               st_lat[sn] = ml;
               st_pol[sn] = {spi_cpol, spi_cpha};
            end
            sn++;
         end else if (ml != 0) begin
            mt++;
            if (mt == 2) spi_done = 1'b0;
            if (mt == ml) begin
               spi_done = 1'b1;
               spi_data_out = spi_data_in;
               ml = 0;
            end
         end
         if (xfer_done) begin
            dn++;
            dcyc = cyc;
         end
         if (rx_valid && rx_ready) begin
            if (rx_n < 512) got_rx[rx_n] = rx_data;
            rx_n++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      while (need > 0 && tx_model.size() > 0) begin
         exp_rx.push_back(tx_model.pop_front());
         need--;
      end
   endtask

   task automatic push_tx(input byte_t b);
      int n = 0;
      tx_data = b;
      tx_valid = 1'b1;
      while (!tx_ready && n < 2000) begin
         tick();
         n++;
      end
      chk("tx_push_timeout", 32'(tx_ready), 1);
      tick();
      tx_valid = 1'b0;
      tx_model.push_back(b);
      settle();
   endtask

   task automatic send_cmd(input int len, input logic pol, input logic pha, output int acc);
      int n = 0;
      while (!cmd_ready && n < 2000) begin
         tick();
         n++;
      end
      chk("cmd_ready_timeout", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_len = 8'(len);
      cmd_cpol = pol;
      cmd_cpha = pha;
      tick();
      acc = cyc - 1;
      cmd_valid = 1'b0;
      need += len;
      settle();
   endtask

   task automatic wait_done(input int goal);
      int n = 0;
      while (dn < goal && n < 3000) begin
         tick();
         n++;
      end
      chk("xfer_done_timeout", 32'(dn >= goal), 1);
   endtask

   task automatic wait_starts(input int goal);
      int n = 0;
      while (sn < goal && n < 2000) begin
         tick();
         n++;
      end
      chk("start_timeout", 32'(sn >= goal), 1);
   endtask

   task automatic check_rx();
      while (rx_seen < rx_n && rx_seen < 512) begin
         if (exp_rx.size() == 0) chk("rx_extra", 32'(got_rx[rx_seen]), 32'hffff_ffff);
         else chk("rx_data", 32'(got_rx[rx_seen]), 32'(exp_rx.pop_front()));
         rx_seen++;
      end
   endtask

   task automatic check_gaps(input int s0);
      for (int i = s0; i + 1 < sn && i + 1 < 256; i++)
         chk("start_gap", 32'(st_cyc[i+1] - st_cyc[i]), 32'(st_lat[i] + 3 + GAP));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_xfer_done"}, 32'(xfer_done), 0);
      chk({tag, "_spi_start"}, 32'(spi_start), 0);
      chk({tag, "_spi_data_in"}, 32'(spi_data_in), 0);
      chk({tag, "_spi_cpol"}, 32'(spi_cpol), 0);
      chk({tag, "_spi_cpha"}, 32'(spi_cpha), 0);
      chk({tag, "_tx_ready"}, 32'(tx_ready), 1);
      chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
      chk({tag, "_rx_data"}, 32'(rx_data), 0);
   endtask

   initial begin
      int s0, d0, acc, s1, len, nb;
      logic [1:0] m2;
      byte_t b;
      repeat (3) tick();
      check_reset_outputs("rst");
      rst = 1'b0;
      tick();
      chk("ready_after_rst", 32'(cmd_ready), 1);

      // loopback burst of three bytes
      s0 = sn; d0 = dn;
      push_tx(8'hA5); push_tx(8'h3C); push_tx(8'hFF);
      send_cmd(3, 1'b0, 1'b0, acc);
      wait_done(d0 + 1);
      repeat (5) tick();
      chk("t1_starts", 32'(sn - s0), 3);
      chk("t1_done_cnt", 32'(dn - d0), 1);
      chk("t1_busy", 32'(busy), 0);
      check_gaps(s0);
      check_rx();
      chk("t1_rx_left", 32'(exp_rx.size()), 0);

      // all four clock modes
      for (int m = 0; m < 4; m++) begin
         m2 = 2'(m);
         s0 = sn; d0 = dn;
         push_tx(8'h81);
         send_cmd(1, m2[1], m2[0], acc);
         wait_done(d0 + 1);
         repeat (3) tick();
         chk("mode_starts", 32'(sn - s0), 1);
         chk("mode_pol", 32'(st_pol[s0]), 32'(m2));
         check_rx();
      end

      // TX starvation
      s0 = sn; d0 = dn;
      push_tx(8'h11);
      send_cmd(2, 1'b0, 1'b0, acc);
      wait_starts(s0 + 1);
      s1 = st_cyc[s0];
      repeat (50) tick();
      chk("starve_no_start", 32'(sn - s0), 1);
      chk("starve_busy", 32'(busy), 1);
      push_tx(8'h22);
      wait_done(d0 + 1);
      repeat (3) tick();
      chk("starve_starts", 32'(sn - s0), 2);
      chk("starve_late", 32'(st_cyc[s0+1] - s1 >= 50), 1);
      check_rx();

      // RX backpressure
      s0 = sn; d0 = dn;
      rx_ready = 1'b0;
      send_cmd(10, 1'b1, 1'b0, acc);
      for (int i = 0; i < 10; i++) push_tx(byte_t'($urandom));
      repeat (200) tick();
      chk("bp_starts", 32'(sn - s0), 9);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_no_done", 32'(dn - d0), 0);
      chk("bp_rx_valid", 32'(rx_valid), 1);
      rx_ready = 1'b1;
      tick(); tick();
      rx_ready = 1'b0;
      wait_done(d0 + 1);
      chk("bp_starts_final", 32'(sn - s0), 10);
      rx_ready = 1'b1;
      repeat (15) tick();
      chk("bp_drained", 32'(rx_valid), 0);
      check_rx();
      chk("bp_rx_left", 32'(exp_rx.size()), 0);

      // zero-length command
      s0 = sn; d0 = dn;
      send_cmd(0, 1'b0, 1'b0, acc);
      wait_done(d0 + 1);
      chk("len0_latency", 32'(dcyc - acc), 2);
      repeat (3) tick();
      chk("len0_no_start", 32'(sn - s0), 0);

      // randomized bursts with leftovers carried between commands
      for (int it = 0; it < 10; it++) begin
         nb = $urandom_range(0, 8 - tx_model.size());
         for (int i = 0; i < nb; i++) push_tx(byte_t'($urandom));
         len = tx_model.size() == 0 ? 0 : int'($urandom_range(0, tx_model.size()));
         m2 = 2'($urandom_range(0, 3));
         s0 = sn; d0 = dn;
         send_cmd(len, m2[1], m2[0], acc);
         wait_done(d0 + 1);
         repeat (4) tick();
         chk("rnd_starts", 32'(sn - s0), 32'(len));
         if (len > 0) chk("rnd_pol", 32'(st_pol[sn-1]), 32'(m2));
         check_gaps(s0);
         check_rx();
      end

      // reset in WAIT of byte 2
      s0 = sn; d0 = dn;
      push_tx(8'h5C); push_tx(8'h7E); push_tx(8'h99);
      send_cmd(3, 1'b1, 1'b1, acc);
      wait_starts(s0 + 2);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      check_rx();
      exp_rx.delete();
      tx_model.delete();
      need = 0;
      tick(); tick();
      rst = 1'b0;
      rx_seen = rx_n;
      repeat (10) tick();
      chk("midrst_no_done", 32'(dn - d0), 0);
      chk("midrst_rx_empty", 32'(rx_valid), 0);
      s0 = sn; d0 = dn;
      push_tx(8'h3A);
      send_cmd(1, 1'b0, 1'b0, acc);
      wait_done(d0 + 1);
      repeat (3) tick();
      chk("post_rst_starts", 32'(sn - s0), 1);
      check_rx();
      chk("final_rx_left", 32'(exp_rx.size()), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
